mux_stream_n: RTL and testbench
===============================

Name: mux_stream_n

Overview:
- Parametrised N-input, W-bit streaming multiplexer with a registered output, successor to the 2:1 combinational mux.
- Adds valid/ready handshakes per channel, static-select and round-robin modes, and packet locking on a last flag.
- Sits between multiple data producers and a single downstream consumer.
- Output carries the source channel index.

Parameters:
- N, 4, number of input channels (N >= 2).
- W, 8, data width per channel.
- SELW, $clog2(N), width of sel and out_chan.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = static select from sel, 1 = round-robin.
- sel  in  SELW  channel index used in static mode.
- in_data  in  N*W  channel i occupies bits [i*W +: W].
- in_valid  in  N  per-channel valid.
- in_last  in  N  per-channel end-of-packet flag.
- in_ready  out  N  per-channel ready.
- out_data  out  W  registered output data.
- out_valid  out  1  output valid.
- out_last  out  1  registered last flag.
- out_chan  out  SELW  source channel of the current output beat.
- out_ready  in  1  downstream ready.
- busy  out  1  high while locked mid-packet.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_data=0, out_last=0, out_chan=0.
  - State = IDLE, rr_ptr=0, lock_idx=0, busy=0.
  - in_ready=0 while in reset.
- can_load = !out_valid || out_ready.
  - One-entry output register.
  - Full throughput of 1 beat/cycle.
  - Latency 1 cycle from input accept to out_valid.
- Grant index g, combinational:
  - IDLE, mode=0: g = sel, granted only if sel < N.
  - IDLE, mode=1: g = first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod N. No grant if no channel is valid.
  - LOCKED: g = lock_idx, regardless of mode and sel.
- in_ready[i] = granted && (i == g) && can_load. All other bits are 0.
  - In static mode, ready may assert on the selected channel with in_valid low.
- Accept = in_valid[g] && in_ready[g]. On accept, next cycle:
  - out_data = channel g data.
  - out_last = in_last[g].
  - out_chan = g.
  - out_valid = 1.
- If no accept and out_ready=1, out_valid goes to 0. out_data, out_last and out_chan hold their last values.
- While out_valid && !out_ready, out_data, out_last and out_chan are stable.
- State machine (2 states):
  - IDLE, accept with last=0 -> LOCKED, lock_idx=g.
  - IDLE, accept with last=1 -> stay IDLE (single-beat packet).
  - LOCKED, accept with last=1 -> IDLE.
  - LOCKED, otherwise -> stay LOCKED.
  - busy = (state == LOCKED).
- rr_ptr update:
  - On every accept with last=1 (either mode), rr_ptr = (g+1) mod N, with wrap N-1 -> 0.
  - Otherwise rr_ptr holds.
- Changes to sel or mode while LOCKED are ignored until the packet ends. They take effect in the first IDLE cycle.
- Valid dropping mid-packet on the locked channel: stay LOCKED and wait. No other channel is granted.
- Reset mid-packet: drop the packet immediately and return to the reset state above.

Test Plan:
1. Static mode, sel=2; ch2 sends 0xA5 with last=1; ch0, ch1 and ch3 are also valid.
   -> in_ready=4'b0100. Next cycle out_data=0xA5, out_chan=2, out_last=1. No other channel is accepted.
2. Backpressure: stream 0x11, 0x22 on ch0 with out_ready=0 for 2 cycles.
   -> out_data holds 0x11 and in_ready=0 during the stall.
   -> 0x22 appears the cycle after out_ready=1. No beat is lost or duplicated.
3. Round-robin: all 4 channels continuously valid with single-beat packets, out_ready=1.
   -> out_chan sequence 0,1,2,3,0,1 at one beat per cycle.
4. Packet lock: RR mode; ch1 sends a 3-beat packet (last on beat 3); ch0 valid throughout; ch2 and ch3 idle.
   -> out_chan 1,1,1 contiguous with busy=1 over beats 1-2.
   -> Then out_chan=0 (rr_ptr=2 wraps to ch0).
5. Static mode, sel changed 2->0 after beat 1 of a 3-beat ch2 packet.
   -> Remaining beats still from ch2. The first beat after the packet comes from ch0.
6. Boundary cases:
   - N=3 instance, sel=3: in_ready=0 and out_valid stays 0.
   - Assert rst_n=0 mid-packet: all outputs 0 immediately, busy=0. After release, RR grants start from ch0.

Source files
------------

// File: rtl/mux_stream_n_if.sv
// mux_stream_n_if: channel-side and downstream-side handshake bundle for mux_stream_n.
interface mux_stream_n_if #(
    parameter int N = 4,
    parameter int W = 8,
    parameter int SELW = $clog2(N)
);
    logic            mode;
    logic [SELW-1:0] sel;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_last;
    logic [N-1:0]    in_ready;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic            out_last;
    logic [SELW-1:0] out_chan;
    logic            out_ready;
    logic            busy;
    modport master (output mode, sel, in_data, in_valid, in_last, out_ready,
                    input in_ready, out_data, out_valid, out_last, out_chan, busy);
    modport slave (input mode, sel, in_data, in_valid, in_last, out_ready,
                   output in_ready, out_data, out_valid, out_last, out_chan, busy);
endinterface

// File: rtl/mux_stream_n.sv
// mux_stream_n: N-way valid/ready stream mux with static or round-robin grant,
// packet locking on last, and a one-entry registered output stage.
module mux_stream_n #(
    parameter int N = 4,
    parameter int W = 8,
    parameter int SELW = $clog2(N)
) (
    input logic clk,
    input logic rst_n,
    mux_stream_n_if.slave s
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t          state;
    logic [SELW-1:0] rr_ptr, lock_idx, rr_g, g;
    logic            rr_hit, granted, can_load, acc, l;
    logic [N-1:0]    ready;
    logic [W-1:0]    d;
    int              j;
    // Scan from the highest offset down so the closest valid channel to rr_ptr wins.
    always_comb begin
        rr_g = rr_ptr;
        rr_hit = 1'b0;
        j = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(rr_ptr) + k) % N;
            if (s.in_valid[j]) begin
                rr_g = SELW'(j);
                rr_hit = 1'b1;
            end
        end
    end
    assign can_load = !s.out_valid || s.out_ready;
    assign g = (state == LOCKED) ? lock_idx : (s.mode ? rr_g : s.sel);
    assign granted = (state == LOCKED) ? 1'b1 : (s.mode ? rr_hit : (int'(s.sel) < N));
    assign ready = (granted && can_load && rst_n) ? (N'(1) << g) : '0;
    assign s.in_ready = ready;
    assign acc = |(s.in_valid & ready);
    always_comb begin
        d = '0;
        l = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (ready[i]) begin
                d = s.in_data[i*W +: W];
                l = s.in_last[i];
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rr_ptr <= '0;
            lock_idx <= '0;
            s.busy <= 1'b0;
            s.out_valid <= 1'b0;
            s.out_data <= '0;
            s.out_last <= 1'b0;
            s.out_chan <= '0;
        end else begin
            if (acc) begin
                s.out_valid <= 1'b1;
                s.out_data <= d;
                s.out_last <= l;
                s.out_chan <= g;
                state <= l ? IDLE : LOCKED;
                s.busy <= !l;
                if (l) rr_ptr <= (g == SELW'(N - 1)) ? '0 : g + 1'b1;
                else lock_idx <= g;
            end else if (s.out_ready) begin
                s.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mux_stream_n.sv
// tb_mux_stream_n: vector table for grant/ready decode plus scoreboarded
// packet sequences covering backpressure, round-robin, locking and reset.
module tb_mux_stream_n;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;

    mux_stream_n_if #(.N(4), .W(8)) bus ();
    mux_stream_n #(.N(4), .W(8)) dut (.clk(clk), .rst_n(rst_n), .s(bus));
    mux_stream_n_if #(.N(3), .W(8)) bus3 ();
    mux_stream_n #(.N(3), .W(8)) dut3 (.clk(clk), .rst_n(rst_n), .s(bus3));

    typedef struct {
        logic [7:0] d;
        logic [1:0] c;
        logic       l;
    } beat_t;
    beat_t q[$];

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] valid;
        logic [3:0] exp_ready;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic [1:0] c, input logic l);
        beat_t b;
        b.d = d;
        b.c = c;
        b.l = l;
        q.push_back(b);
    endtask

    task automatic set_ch(input int ch, input logic [7:0] d, input logic l);
        bus.in_data[ch*8 +: 8] = d;
        bus.in_last[ch] = l;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        bus.in_valid = '0;
        bus.out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drain(input string name);
        repeat (3) tick();
        chk({name, "_drained"}, q.size(), 0);
        q.delete();
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got data %0h chan %0d, none expected", bus.out_data, bus.out_chan);
            end else begin
                beat_t e;
                e = q.pop_front();
                chk("beat", {bus.out_data, bus.out_chan, bus.out_last}, {e.d, e.c, e.l});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b0, 2'd0, 4'b0000, 4'b0001};
        vecs[1] = '{1'b0, 2'd2, 4'b1111, 4'b0100};
        vecs[2] = '{1'b0, 2'd3, 4'b0000, 4'b1000};
        vecs[3] = '{1'b1, 2'd0, 4'b0000, 4'b0000};
        vecs[4] = '{1'b1, 2'd0, 4'b1010, 4'b0010};
        vecs[5] = '{1'b1, 2'd1, 4'b1000, 4'b1000};
        vecs[6] = '{1'b1, 2'd3, 4'b1111, 4'b0001};

        bus.mode = 1'b0;
        bus.sel = '0;
        bus.in_data = 32'h13121110;
        bus.in_valid = 4'b1111;
        bus.in_last = 4'b1111;
        bus.out_ready = 1'b1;
        bus3.mode = 1'b0;
        bus3.sel = 2'd3;
        bus3.in_data = 24'h232221;
        bus3.in_valid = 3'b111;
        bus3.in_last = 3'b111;
        bus3.out_ready = 1'b1;
        #3;
        chk("reset_state", {bus.out_valid, bus.out_data, bus.out_last, bus.out_chan, bus.busy, bus.in_ready}, 0);
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            tick();
            rst_n = 1'b0;
            bus.in_valid = '0;
            tick();
            rst_n = 1'b1;
            bus.mode = vecs[i].mode;
            bus.sel = vecs[i].sel;
            bus.in_valid = vecs[i].valid;
            @(negedge clk);
            chk($sformatf("vec%0d_ready", i), bus.in_ready, vecs[i].exp_ready);
        end

        // static select, other channels valid too
        do_reset();
        bus.mode = 1'b0;
        bus.sel = 2'd2;
        bus.in_data = 32'h13A51110;
        bus.in_last = 4'b1111;
        bus.in_valid = 4'b1111;
        push(8'hA5, 2'd2, 1'b1);
        @(negedge clk);
        chk("t1_ready", bus.in_ready, 4'b0100);
        tick();
        bus.in_valid = '0;
        drain("t1");

        // backpressure
        do_reset();
        bus.sel = 2'd0;
        bus.out_ready = 1'b0;
        set_ch(0, 8'h11, 1'b1);
        bus.in_valid = 4'b0001;
        push(8'h11, 2'd0, 1'b1);
        tick();
        set_ch(0, 8'h22, 1'b1);
        push(8'h22, 2'd0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t2_stall_ready", bus.in_ready, 0);
            chk("t2_stall_data", {bus.out_valid, bus.out_data}, 9'h111);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = '0;
        drain("t2");

        // round-robin, single-beat packets on every channel
        do_reset();
        bus.mode = 1'b1;
        bus.in_data = 32'h33323130;
        bus.in_last = 4'b1111;
        bus.in_valid = 4'b1111;
        for (int i = 0; i < 6; i++) push(8'h30 + 8'(i % 4), 2'(i % 4), 1'b1);
        repeat (6) @(posedge clk);
        #1;
        bus.in_valid = '0;
        drain("t3");

        // packet lock in RR mode, including a valid gap on the locked channel
        do_reset();
        bus.mode = 1'b1;
        set_ch(1, 8'h51, 1'b0);
        set_ch(0, 8'h40, 1'b1);
        bus.in_valid = 4'b0010;
        push(8'h51, 2'd1, 1'b0);
        tick();
        set_ch(1, 8'h52, 1'b0);
        bus.in_valid = 4'b0011;
        push(8'h52, 2'd1, 1'b0);
        @(negedge clk);
        chk("t4_locked_ready", bus.in_ready, 4'b0010);
        chk("t4_busy1", bus.busy, 1'b1);
        tick();
        bus.in_valid = 4'b0001;
        @(negedge clk);
        chk("t4_gap_ready", bus.in_ready, 4'b0010);
        chk("t4_busy2", bus.busy, 1'b1);
        tick();
        set_ch(1, 8'h53, 1'b1);
        bus.in_valid = 4'b0011;
        push(8'h53, 2'd1, 1'b1);
        tick();
        bus.in_valid = 4'b0001;
        push(8'h40, 2'd0, 1'b1);
        @(negedge clk);
        chk("t4_after_ready", bus.in_ready, 4'b0001);
        chk("t4_busy_clear", bus.busy, 1'b0);
        tick();
        bus.in_valid = '0;
        drain("t4");

        // sel change while locked in static mode
        do_reset();
        bus.mode = 1'b0;
        bus.sel = 2'd2;
        set_ch(2, 8'h71, 1'b0);
        set_ch(0, 8'h60, 1'b1);
        bus.in_valid = 4'b0101;
        push(8'h71, 2'd2, 1'b0);
        tick();
        bus.sel = 2'd0;
        set_ch(2, 8'h72, 1'b0);
        push(8'h72, 2'd2, 1'b0);
        @(negedge clk);
        chk("t5_locked_ready", bus.in_ready, 4'b0100);
        tick();
        set_ch(2, 8'h73, 1'b1);
        push(8'h73, 2'd2, 1'b1);
        tick();
        bus.in_valid = 4'b0001;
        push(8'h60, 2'd0, 1'b1);
        @(negedge clk);
        chk("t5_after_ready", bus.in_ready, 4'b0001);
        tick();
        bus.in_valid = '0;
        drain("t5");

        // out-of-range select on the 3-channel instance
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("n3_ready", bus3.in_ready, 0);
            chk("n3_out_valid", bus3.out_valid, 1'b0);
        end

        // reset mid-packet
        do_reset();
        bus.mode = 1'b1;
        set_ch(2, 8'h81, 1'b0);
        bus.in_valid = 4'b0100;
        push(8'h81, 2'd2, 1'b0);
        tick();
        bus.in_valid = '0;
        @(negedge clk);
        chk("t6_busy_before", bus.busy, 1'b1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("t6_reset_outs", {bus.out_valid, bus.out_data, bus.out_last, bus.out_chan, bus.busy, bus.in_ready}, 0);
        tick();
        rst_n = 1'b1;
        bus.in_data = 32'h93929190;
        bus.in_last = 4'b1111;
        bus.in_valid = 4'b1111;
        push(8'h90, 2'd0, 1'b1);
        @(negedge clk);
        chk("t6_rr_restart", bus.in_ready, 4'b0001);
        tick();
        bus.in_valid = '0;
        drain("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
